// File: rtl/micro_branch_control.sv
// Purpose: branch-control stage of a microsequencer. It registers the control-store word and decodes the sequencer op, address and datapath ctl fields.
// Latency: one register stage (PR) from uword; op/relative/din/taken/ctl are combinational from PR, cond and the loop counter.
// Backpressure: none; a new microword is accepted every clock. WAIT stalls the sequencer by refetching the same address.
// Optional feature: define STACK_CHECK_EN to add the call/return depth tracker that drives the sticky stack_err flag.
module micro_branch_control #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] uword,
    input  logic [7:0]  cond,
    output logic [1:0]  op,
    output logic        relative,
    output logic [11:0] din,
    output logic [11:0] ctl,
    output logic        taken,
    output logic        stack_err
);

    // Microword type codes held in PR[31:29]
    typedef enum logic [2:0] {
        T_CONT = 3'd0,
        T_JMP  = 3'd1,
        T_CALL = 3'd2,
        T_RET  = 3'd3,
        T_LDCT = 3'd4,
        T_LOOP = 3'd5,
        T_WAIT = 3'd6,
        T_RSVD = 3'd7
    } utype_t;

    // Sequencer operation codes presented on op
    typedef enum logic [1:0] {
        OP_NEXT = 2'd0,
        OP_JUMP = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } seq_op_t;

    // WAIT refetches its own address: a relative offset of -1 back to the current word
    localparam logic [11:0] WAIT_OFFSET = 12'hFFF;

    logic [31:0] pr_q;
    logic [11:0] loop_cnt_q;

    utype_t      pr_type;
    logic [2:0]  pr_csel;
    logic        pr_pol;
    logic        pr_rel;
    logic [11:0] pr_addr;
    logic [11:0] pr_ctl;

    logic        cond_bit;
    logic        test_true;
    logic        cnt_nonzero;

    seq_op_t     op_sel;
    logic        rel_sel;
    logic [11:0] din_sel;
    logic        taken_sel;
    logic        cnt_load;
    logic        cnt_dec;
    logic        call_taken;
    logic        ret_taken;

    // Pipeline register: captures the control-store word every clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pr_q <= 32'd0;
        end else begin
            pr_q <= uword;
        end
    end

    // Field split of the pipelined microword
    always_comb begin
        pr_type = utype_t'(pr_q[31:29]);
        pr_csel = pr_q[28:26];
        pr_pol  = pr_q[25];
        pr_rel  = pr_q[24];
        pr_addr = pr_q[23:12];
        pr_ctl  = pr_q[11:0];
    end

    // Branch test: select 0 is "always", otherwise one datapath condition bit; pol inverts the sense
    always_comb begin
        cond_bit    = (pr_csel == 3'd0) ? 1'b1 : cond[pr_csel];
        test_true   = cond_bit ^ pr_pol;
        cnt_nonzero = (loop_cnt_q != 12'd0);
    end

    // Sequencer decode: op/address select per microword type, plus counter load/decrement strobes
    always_comb begin
        op_sel    = OP_NEXT;
        rel_sel   = 1'b0;
        din_sel   = 12'd0;
        taken_sel = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (pr_type)
            T_JMP: begin
                if (test_true) begin
                    op_sel    = OP_JUMP;
                    rel_sel   = pr_rel;
                    din_sel   = pr_addr;
                    taken_sel = 1'b1;
                end
            end
            T_CALL: begin
                if (test_true) begin
                    op_sel    = OP_CALL;
                    rel_sel   = pr_rel;
                    din_sel   = pr_addr;
                    taken_sel = 1'b1;
                end
            end
            T_RET: begin
                // Return address comes from the sequencer's own stack, so din stays 0
                if (test_true) begin
                    op_sel    = OP_RET;
                    taken_sel = 1'b1;
                end
            end
            T_LDCT: begin
                cnt_load = 1'b1;
            end
            T_LOOP: begin
                // Counter saturates at zero: the loop falls through instead of wrapping
                if (cnt_nonzero) begin
                    op_sel    = OP_JUMP;
                    rel_sel   = pr_rel;
                    din_sel   = pr_addr;
                    taken_sel = 1'b1;
                    cnt_dec   = 1'b1;
                end
            end
            T_WAIT: begin
                // Spin on the current address until the condition becomes true
                if (!test_true) begin
                    op_sel    = OP_JUMP;
                    rel_sel   = 1'b1;
                    din_sel   = WAIT_OFFSET;
                    taken_sel = 1'b1;
                end
            end
            T_CONT, T_RSVD: begin
                op_sel = OP_NEXT;
            end
            default: begin
                op_sel = OP_NEXT;
            end
        endcase
    end

    // Output drive; reset forces the quiet state even before PR has been cleared through
    always_comb begin
        if (reset) begin
            op       = 2'd0;
            relative = 1'b0;
            din      = 12'd0;
            ctl      = 12'd0;
            taken    = 1'b0;
        end else begin
            op       = op_sel;
            relative = rel_sel;
            din      = din_sel;
            ctl      = pr_ctl;
            taken    = taken_sel;
        end
    end

    // Loop counter: loaded by LDCT, decremented by each taken LOOP, otherwise held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loop_cnt_q <= 12'd0;
        end else if (cnt_load) begin
            loop_cnt_q <= pr_addr;
        end else if (cnt_dec) begin
            loop_cnt_q <= loop_cnt_q - 12'd1;
        end
    end

    // Taken call/return strobes, used by the depth tracker when it is compiled in
    always_comb begin
        call_taken = (pr_type == T_CALL) && test_true;
        ret_taken  = (pr_type == T_RET) && test_true;
    end

`ifdef STACK_CHECK_EN
    localparam int DEPTH_W = (STACK_DEPTH < 1) ? 1 : $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [DEPTH_W-1:0] depth_q;
    logic               stack_err_q;

    // Depth tracker: mirrors the sequencer's return stack occupancy and saturates at both ends
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q     <= '0;
            stack_err_q <= 1'b0;
        end else if (call_taken) begin
            if (depth_q == DEPTH_MAX) begin
                stack_err_q <= 1'b1;
            end else begin
                depth_q <= depth_q + DEPTH_W'(1);
            end
        end else if (ret_taken) begin
            if (depth_q == '0) begin
                stack_err_q <= 1'b1;
            end else begin
                depth_q <= depth_q - DEPTH_W'(1);
            end
        end
    end

    assign stack_err = stack_err_q;
`else
    logic unused_stack_strobes;

    // No depth tracking in this build: the strobes are left unconsumed and the flag is tied off
    assign unused_stack_strobes = call_taken | ret_taken;
    assign stack_err            = 1'b0;
`endif

endmodule

// File: tb/tb_micro_branch_control.sv
module tb_micro_branch_control;

    localparam int SD = 4;

    logic        clock;
    logic        reset;
    logic [31:0] uword;
    logic [7:0]  cond;
    logic [1:0]  op;
    logic        relative;
    logic [11:0] din;
    logic [11:0] ctl;
    logic        taken;
    logic        stack_err;

    int n_assert;
    int n_fail;

    // Reference model state
    logic [31:0] m_pr;
    int          m_cnt;
    int          m_depth;
    logic        m_err;

    // Expected outputs
    int          e_op;
    int          e_rel;
    int          e_din;
    int          e_ctl;
    int          e_taken;

    micro_branch_control #(.STACK_DEPTH(SD)) dut (
        .clock     (clock),
        .reset     (reset),
        .uword     (uword),
        .cond      (cond),
        .op        (op),
        .relative  (relative),
        .din       (din),
        .ctl       (ctl),
        .taken     (taken),
        .stack_err (stack_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input int typ, input int csel, input int pol,
                                       input int rel, input int addr, input int c);
        logic [31:0] w;
        w = ((typ & 7) << 29) | ((csel & 7) << 26) | ((pol & 1) << 25) |
            ((rel & 1) << 24) | ((addr & 12'hFFF) << 12) | (c & 12'hFFF);
        return w;
    endfunction

    function automatic int test_of(input logic [31:0] w, input logic [7:0] c);
        int csel;
        int pol;
        int t;
        csel = (w >> 26) & 7;
        pol  = (w >> 25) & 1;
        t    = (csel == 0) ? 1 : ((c >> csel) & 1);
        return t ^ pol;
    endfunction

    task automatic compute_expected();
        int typ;
        int addr;
        int rel;
        int t;
        typ  = (m_pr >> 29) & 7;
        rel  = (m_pr >> 24) & 1;
        addr = (m_pr >> 12) & 12'hFFF;
        t    = test_of(m_pr, cond);
        e_op = 0; e_rel = 0; e_din = 0; e_taken = 0;
        e_ctl = m_pr & 12'hFFF;
        if ((typ == 1 || typ == 2) && t == 1) begin
            e_op = typ; e_rel = rel; e_din = addr; e_taken = 1;
        end else if (typ == 3 && t == 1) begin
            e_op = 3; e_taken = 1;
        end else if (typ == 5 && m_cnt > 0) begin
            e_op = 1; e_rel = rel; e_din = addr; e_taken = 1;
        end else if (typ == 6 && t == 0) begin
            e_op = 1; e_rel = 1; e_din = 12'hFFF; e_taken = 1;
        end
    endtask

    task automatic model_edge();
        int typ;
        int t;
        typ = (m_pr >> 29) & 7;
        t   = test_of(m_pr, cond);
        if (typ == 4) m_cnt = (m_pr >> 12) & 12'hFFF;
        else if (typ == 5 && m_cnt > 0) m_cnt = m_cnt - 1;
`ifdef STACK_CHECK_EN
        if (typ == 2 && t == 1) begin
            if (m_depth == SD) m_err = 1'b1;
            else m_depth = m_depth + 1;
        end else if (typ == 3 && t == 1) begin
            if (m_depth == 0) m_err = 1'b1;
            else m_depth = m_depth - 1;
        end
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        compute_expected();
        chk({tag, ".op"},        {30'd0, op},       32'(e_op));
        chk({tag, ".relative"},  {31'd0, relative}, 32'(e_rel));
        chk({tag, ".din"},       {20'd0, din},      32'(e_din));
        chk({tag, ".ctl"},       {20'd0, ctl},      32'(e_ctl));
        chk({tag, ".taken"},     {31'd0, taken},    32'(e_taken));
        chk({tag, ".stack_err"}, {31'd0, stack_err}, {31'd0, m_err});
    endtask

    // One cycle: present uw before the edge, update cond after it, check away from the edge
    task automatic step(input logic [31:0] uw, input logic [7:0] cd, input string tag);
        uword = uw;
        @(posedge clock);
        model_edge();
        m_pr = uw;
        #1 cond = cd;
        #1 check_all(tag);
        @(negedge clock);
    endtask

    task automatic model_reset();
        m_pr = 32'd0; m_cnt = 0; m_depth = 0; m_err = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle, checked while high, released at a falling edge
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all(tag);
        @(posedge clock);
        #1 check_all({tag, "_hold"});
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        cond     = 8'h00;
        uword    = mk(1, 0, 0, 0, 12'h055, 12'h3A5);
        model_reset();

        // Reset state with a JMP waiting on uword
        #3;
        check_all("reset");
        chk("reset.ctl_zero", {20'd0, ctl}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step(mk(1, 0, 0, 0, 12'h055, 12'h3A5), 8'h00, "first_jmp");
        chk("first_jmp.op", {30'd0, op}, 32'd1);
        chk("first_jmp.din", {20'd0, din}, 32'h055);

        // Conditional jump on cond[3]
        step(mk(1, 3, 0, 1, 12'h010, 12'h111), 8'h00, "cjmp_false");
        chk("cjmp_false.op", {30'd0, op}, 32'd0);
        #1 cond = 8'h08;
        #1 check_all("cjmp_true");
        chk("cjmp_true.din", {20'd0, din}, 32'h010);
        @(negedge clock);

        // Loop count: LDCT 3 then LOOP repeated
        begin
            int taken_cnt;
            taken_cnt = 0;
            step(mk(4, 0, 0, 0, 3, 12'h222), 8'h00, "ldct");
            for (int i = 0; i < 6; i++) begin
                step(mk(5, 0, 0, 1, 12'h7F0, 12'h333), 8'h00, "loop");
                if (taken === 1'b1) taken_cnt++;
            end
            chk("loop.taken_count", 32'(taken_cnt), 32'd3);
            chk("loop.exit_op", {30'd0, op}, 32'd0);
        end

        // WAIT on cond[1]
        for (int i = 0; i < 5; i++) begin
            step(mk(6, 1, 0, 0, 12'h0AA, 12'h444), 8'h00, "wait_spin");
            chk("wait_spin.din", {20'd0, din}, 32'hFFF);
        end
        step(mk(6, 1, 0, 0, 12'h0AA, 12'h444), 8'h02, "wait_done");
        chk("wait_done.op", {30'd0, op}, 32'd0);

        // Reserved type with assorted conditions
        for (int i = 0; i < 4; i++) begin
            step(mk(7, i, i & 1, 1, 12'h5A5, 12'h100 + i), 8'($urandom), "reserved");
        end

        // Stack check: five taken CALLs, then underflow after reset
        do_reset("reset_stack");
        for (int i = 0; i < 5; i++) step(mk(2, 0, 0, 0, 12'h020 + i, 12'h0), 8'h00, "call");
        step(mk(0, 0, 0, 0, 0, 12'h001), 8'h00, "after_calls");
`ifdef STACK_CHECK_EN
        chk("overflow.stack_err", {31'd0, stack_err}, 32'd1);
`else
        chk("overflow.stack_err", {31'd0, stack_err}, 32'd0);
`endif
        do_reset("reset_ret");
        step(mk(3, 0, 0, 0, 0, 12'h002), 8'h00, "ret");
        step(mk(0, 0, 0, 0, 0, 12'h003), 8'h00, "after_ret");

        // Reset in the middle of a counted loop abandons it
        step(mk(4, 0, 0, 0, 5, 12'h0), 8'h00, "ldct5");
        step(mk(5, 0, 0, 0, 12'h040, 12'h0), 8'h00, "loop5");
        step(mk(5, 0, 0, 0, 12'h040, 12'h0), 8'h00, "loop5");
        do_reset("reset_midloop");
        step(mk(5, 0, 0, 0, 12'h040, 12'h0), 8'h00, "loop_after_reset");
        chk("loop_after_reset.op", {30'd0, op}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int typ;
            int addr;
            typ  = $urandom_range(0, 7);
            addr = (typ == 4) ? $urandom_range(0, 6) : $urandom_range(0, 4095);
            step(mk(typ, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                    addr, $urandom_range(0, 4095)), 8'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_branch_control.md
MICRO_BRANCH_CONTROL -- requirements
Module: micro_branch_control

Interface
REQ-001 SHALL have parameter: STACK_DEPTH, default 4, return-stack entries in the paired sequencer (depth-check limit).
REQ-002 SHALL have port: clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port: uword  input  32  microword read from control store at the current sequencer address.
REQ-005 SHALL have port: cond  input  8  condition inputs from the datapath.
REQ-006 SHALL have port: op  output  2  sequencer operation: 0 next, 1 jump, 2 call, 3 return.
REQ-007 SHALL have port: relative  output  1  sequencer relative-address select.
REQ-008 SHALL have port: din  output  12  sequencer branch address or offset.
REQ-009 SHALL have port: ctl  output  12  datapath control field of the pipelined microword.
REQ-010 SHALL have port: taken  output  1  high when the current microword's branch/call/return/wait is executed.
REQ-011 SHALL have port: stack_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-012 SHALL register uword into a 32-bit pipeline register (PR) every clock; PR fields: [31:29] type, [28:26] csel, [25] pol, [24] rel, [23:12] addr, [11:0] ctl.
REQ-013 SHALL drive op, relative, din, taken and ctl combinationally from PR, cond and the loop counter, giving zero added latency after the PR.
REQ-014 SHALL compute the test as: csel=0 -> 1; else cond[csel]; then XOR pol. The test is ignored for types 0, 4 and 5.
REQ-015 Type 0 CONT: SHALL drive op=0, taken=0.
REQ-016 Type 1 JMP: if the test is true, SHALL drive op=1, relative=rel, din=addr, taken=1; else op=0.
REQ-017 Type 2 CALL: if the test is true, SHALL drive op=2, relative=rel, din=addr, taken=1; else op=0.
REQ-018 Type 3 RET: if the test is true, SHALL drive op=3, taken=1; else op=0.
REQ-019 Type 4 LDCT: SHALL drive op=0 and load the 12-bit loop counter with addr at the clock edge.
REQ-020 Type 5 LOOP: if counter!=0, SHALL drive op=1, relative=rel, din=addr, taken=1, and decrement the counter at the edge; if counter==0, SHALL drive op=0 and hold the counter at 0 (no wrap).
REQ-021 Type 6 WAIT: if the test is false, SHALL drive op=1, relative=1, din=12'hFFF, taken=1, refetching the same address; if the test is true, SHALL drive op=0.
REQ-022 Type 7 (reserved): SHALL behave as CONT.
REQ-023 When op is not 1 or 2, SHALL drive relative=0 and din=0.
REQ-024 SHALL pass ctl=PR[11:0] unchanged for all types.

Reset
REQ-025 While reset is high, SHALL clear PR, the loop counter, stack depth and stack_err to 0.
REQ-026 While reset is high, SHALL drive op=0, relative=0, din=0, ctl=0, taken=0.
REQ-027 SHALL resume with PR loading uword at the first rising clock after reset deasserts.
REQ-028 Reset asserted mid-LOOP or mid-WAIT SHALL abandon the sequence immediately, with no counter decrement on that edge.

Configuration
REQ-029 Macro STACK_CHECK_EN, when defined, SHALL compile in a depth counter over 0..STACK_DEPTH.
REQ-030 With STACK_CHECK_EN defined: a taken CALL SHALL increment depth; a taken RET SHALL decrement depth.
REQ-031 With STACK_CHECK_EN defined: a taken CALL at depth STACK_DEPTH SHALL set stack_err and hold depth.
REQ-032 With STACK_CHECK_EN defined: a taken RET at depth 0 SHALL set stack_err and hold depth at 0.
REQ-033 With STACK_CHECK_EN defined: stack_err SHALL remain set until reset.
REQ-034 Without STACK_CHECK_EN: there SHALL be no depth logic and stack_err SHALL be tied to 0.

Verification
REQ-035 Scenario (reset): reset pulse while uword=JMP addr 12'h055 -> op=0, din=0, ctl=0, taken=0 during reset; op=1, din=12'h055 after the first edge.
REQ-036 Scenario (conditional jump): PR=JMP csel=3 pol=0 rel=1 addr=12'h010 with cond[3]=0 -> op=0; with cond[3]=1 -> op=1, relative=1, din=12'h010.
REQ-037 Scenario (loop count): LDCT addr=3, then LOOP repeated -> taken high for exactly 3 LOOP cycles (counter 3->2->1->0), then op=0 with the counter held at 0.
REQ-038 Scenario (wait): WAIT csel=1 pol=0 with cond[1] low for 5 cycles -> op=1, relative=1, din=12'hFFF for 5 cycles; op=0 on the cycle cond[1] rises.
REQ-039 Scenario (stack check, STACK_CHECK_EN): 5 taken CALLs -> stack_err rises on the 5th; after reset, 1 taken RET -> stack_err=1; without the macro, stack_err stays 0 throughout.
REQ-040 Scenario (reserved type): type 7 with any cond -> op=0, taken=0, ctl=PR[11:0].
